// File: rtl/mux_scan_pkg.sv
// Shared state encoding and widths for the 4:1 mux scan sequencer.
package mux_scan_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  localparam int CH_COUNT = 4;
  localparam int CH_W     = 2;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETTLE = SETTLE,
    ST_HOLD   = HOLD
  } state_t;

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(CH_COUNT - 1);

endpackage

// File: rtl/mux_scan_settle_counter.sv
// Loadable settle down-counter; tc is high once the programmed settle time has elapsed.
module mux_scan_settle_counter
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux through channels 0..3, samples each after a settle time, and offers
// the packed word on valid/ready. Optional data_parity output under MUX_SCAN_PARITY_EN.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  output logic       address0,
  output logic       address1,
  output logic       busy,
  output logic [3:0] data_word,
  output logic       data_valid,
  input  logic       data_ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic       data_parity
`endif
);

  state_t            state_reg, state_next;
  logic [CH_W-1:0]   ch_reg, ch_next;
  logic [3:0]        data_word_reg, data_word_next;
  logic              valid_reg, valid_next;
  logic              busy_reg, busy_next;
  logic              cnt_clear, cnt_load, cnt_dec, cnt_tc;

  // The counter is preloaded with the settle time, so tc marks the sampling cycle.
  mux_scan_settle_counter u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value (CNT_W'(SETTLE_CYCLES)),
    .dec        (cnt_dec),
    .tc         (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      ch_reg        <= '0;
      data_word_reg <= '0;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ch_reg        <= ch_next;
      data_word_reg <= data_word_next;
      valid_reg     <= valid_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    data_word_next = data_word_reg;
    valid_next     = valid_reg;
    busy_next      = busy_reg;
    cnt_clear      = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next     = ST_SETTLE;
          ch_next        = '0;
          busy_next      = 1'b1;
          data_word_next = '0;
          cnt_load       = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!cnt_tc) begin
          cnt_dec = 1'b1;
        end else begin
          data_word_next[ch_reg] = mux_out;
          if (ch_reg == LAST_CH) begin
            state_next = ST_HOLD;
            valid_next = 1'b1;
            cnt_clear  = 1'b1;
          end else begin
            ch_next  = ch_reg + CH_W'(1);
            cnt_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        // start is deliberately ignored here, even alongside data_ready.
        if (data_ready) begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
          busy_next  = 1'b0;
          ch_next    = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign address0   = ch_reg[0];
  assign address1   = ch_reg[1];
  assign busy       = busy_reg;
  assign data_word  = data_word_reg;
  assign data_valid = valid_reg;

`ifdef MUX_SCAN_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else begin
      parity_reg <= ^data_word_next;
    end
  end

  assign data_parity = parity_reg;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (settle 2 and 0), each scanning a gate-level 4:1 mux.
module tb_mux_scan_sequencer;

  localparam int S_A = 2;
  localparam int S_B = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] start_v, ready_v, mux_v, a0_v, a1_v, busy_v, valid_v;
  logic [3:0] ins_v  [2];
  logic [3:0] word_v [2];
  logic [3:0] hist [2][4096];
  int         edge_cnt = 0;
  int         checks   = 0;
  int         errors   = 0;
`ifdef MUX_SCAN_PARITY_EN
  logic [1:0] parity_v;
`endif

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mux
      assign mux_v[gi] = (~a1_v[gi] & ~a0_v[gi] & ins_v[gi][0]) |
                         (~a1_v[gi] &  a0_v[gi] & ins_v[gi][1]) |
                         ( a1_v[gi] & ~a0_v[gi] & ins_v[gi][2]) |
                         ( a1_v[gi] &  a0_v[gi] & ins_v[gi][3]);
    end
  endgenerate

  mux_scan_sequencer #(.SETTLE_CYCLES(S_A)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_v[0]),
    .mux_out    (mux_v[0]),
    .address0   (a0_v[0]),
    .address1   (a1_v[0]),
    .busy       (busy_v[0]),
    .data_word  (word_v[0]),
    .data_valid (valid_v[0]),
    .data_ready (ready_v[0])
`ifdef MUX_SCAN_PARITY_EN
    ,
    .data_parity(parity_v[0])
`endif
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(S_B)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_v[1]),
    .mux_out    (mux_v[1]),
    .address0   (a0_v[1]),
    .address1   (a1_v[1]),
    .busy       (busy_v[1]),
    .data_word  (word_v[1]),
    .data_valid (valid_v[1]),
    .data_ready (ready_v[1])
`ifdef MUX_SCAN_PARITY_EN
    ,
    .data_parity(parity_v[1])
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Record the mux inputs seen at this edge, then advance one clock.
  task automatic step();
    hist[0][edge_cnt] = ins_v[0];
    hist[1][edge_cnt] = ins_v[1];
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic chk_idle(input int sel, input string tag, input logic [3:0] word_exp);
    chk({tag, "_busy"},  8'(busy_v[sel]),  8'd0);
    chk({tag, "_valid"}, 8'(valid_v[sel]), 8'd0);
    chk({tag, "_addr"},  8'({a1_v[sel], a0_v[sel]}), 8'd0);
    chk({tag, "_word"},  8'(word_v[sel]),  8'(word_exp));
  endtask

  // One complete scan. Expected word: bit i is the in_i value present at edge
  // accept + (i+1)*(settle+1); expected address after edge accept+m is m/(settle+1).
  task automatic scan(input int sel, input int hold, input bit jitter, input bit start_in_hold);
    int         s;
    int         a;
    int         n;
    logic [3:0] exp_word;
    s = (sel == 0) ? S_A : S_B;
    n = 4 * (s + 1);
    a = edge_cnt;
    start_v[sel] = 1'b1;
    ready_v[sel] = 1'b1;
    step();
    start_v[sel] = 1'b0;
    for (int m = 0; m < n; m++) begin
      chk("scan_busy",  8'(busy_v[sel]),  8'd1);
      chk("scan_valid", 8'(valid_v[sel]), 8'd0);
      chk("scan_addr",  8'({a1_v[sel], a0_v[sel]}), 8'(m / (s + 1)));
      if (m == 0) chk("scan_word_clr", 8'(word_v[sel]), 8'd0);
      if (jitter) begin
        ins_v[sel]   = 4'($urandom);
        start_v[sel] = 1'($urandom);
        ready_v[sel] = 1'($urandom);
      end
      step();
    end
    for (int i = 0; i < 4; i++) exp_word[i] = hist[sel][a + (i + 1) * (s + 1)][i];
    chk("valid_rise", 8'(valid_v[sel]), 8'd1);
    chk("word",       8'(word_v[sel]),  8'(exp_word));
    chk("hold_addr",  8'({a1_v[sel], a0_v[sel]}), 8'd3);
`ifdef MUX_SCAN_PARITY_EN
    chk("parity", 8'(parity_v[sel]), 8'(^exp_word));
`endif
    for (int h = 0; h < hold; h++) begin
      ready_v[sel] = 1'b0;
      start_v[sel] = start_in_hold ? 1'($urandom) : 1'b0;
      if (jitter) ins_v[sel] = 4'($urandom);
      step();
      chk("hold_valid", 8'(valid_v[sel]), 8'd1);
      chk("hold_word",  8'(word_v[sel]),  8'(exp_word));
      chk("hold_busy",  8'(busy_v[sel]),  8'd1);
      chk("hold_addr2", 8'({a1_v[sel], a0_v[sel]}), 8'd3);
    end
    ready_v[sel] = 1'b1;
    start_v[sel] = start_in_hold;
    step();
    chk_idle(sel, "handshake", exp_word);
    ready_v[sel] = 1'b0;
    start_v[sel] = 1'b0;
    step();
    chk_idle(sel, "post_idle", exp_word);
  endtask

  initial begin
    rst_n    = 1'b0;
    start_v  = '0;
    ready_v  = '0;
    ins_v[0] = '0;
    ins_v[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_idle(0, "reset_a", 4'd0);
    chk_idle(1, "reset_b", 4'd0);
    rst_n = 1'b1;
    step();
    chk_idle(0, "idle_a", 4'd0);

    // in0..in3 = 1,0,1,1 with data_ready held high
    ins_v[0] = 4'b1101;
    scan(0, 0, 1'b0, 1'b0);

    // consumer stalls 5 cycles while start is pulsed
    ins_v[0] = 4'b1010;
    scan(0, 5, 1'b0, 1'b1);

    // data_ready in IDLE does nothing
    ready_v[0] = 1'b1;
    repeat (3) step();
    chk_idle(0, "ready_idle", 4'b1010);
    ready_v[0] = 1'b0;

    // asynchronous reset mid-scan
    ins_v[0]   = 4'b1111;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    chk_idle(0, "async_rst_a", 4'd0);
    chk_idle(1, "async_rst_b", 4'd0);
    rst_n = 1'b1;
    step();
    chk_idle(0, "after_rst", 4'd0);
    ins_v[0] = 4'b0110;
    scan(0, 0, 1'b0, 1'b0);

    // zero settle: one cycle per channel
    ins_v[1] = 4'b1000;
    scan(1, 0, 1'b0, 1'b0);

    // parity patterns (word is checked in either build)
    ins_v[0] = 4'b0111;
    scan(0, 0, 1'b0, 1'b0);
    ins_v[0] = 4'b0011;
    scan(0, 1, 1'b0, 1'b0);

    // randomized scans with inputs, start and ready changing mid-scan
    for (int r = 0; r < 20; r++) begin
      int sel;
      sel = int'($urandom_range(0, 1));
      ins_v[sel] = 4'($urandom);
      scan(sel, int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
